// File: rtl/mipi_csi2_pkt_rx.sv
// mipi_csi2_pkt_rx: single-lane CSI-2 packet header parser and payload gate.
// Optional payload CRC-16 check enabled by defining MIPI_PKT_CRC_EN.
module mipi_csi2_pkt_rx #(
   parameter logic [5:0] LONG_DT_MIN = 6'h10,
   parameter logic [5:0] FS_DT       = 6'h00,
   parameter logic [5:0] FE_DT       = 6'h01
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        we,
   input  logic [7:0]  data,
   output logic        frame_valid,
   output logic        line_valid,
   output logic        dat_valid,
   output logic [7:0]  dat,
   output logic [5:0]  data_type,
   output logic [1:0]  virtual_channel,
   output logic [15:0] word_count,
   output logic        pkt_done,
   output logic        trunc_err,
   output logic        crc_err
);

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_HDR     = 3'd1;
   localparam logic [2:0] ST_PAYLOAD = 3'd2;
   localparam logic [2:0] ST_CRC     = 3'd3;
   localparam logic [2:0] ST_DRAIN   = 3'd4;

   logic [2:0]  r_state;
   logic [1:0]  r_hdr_cnt;
   logic [15:0] r_cnt;
   logic        r_crc_ph;

`ifdef MIPI_PKT_CRC_EN
   logic [15:0] r_crc;
   logic [7:0]  r_crc_lo;

   // Reflected CRC-16 (0x8408) over one byte, LSB first.
   function automatic logic [15:0] crc_upd(
      input logic [15:0] c,
      input logic [7:0]  b
   );
      logic [15:0] v;
      v = c ^ {8'h00, b};
      for (int i = 0; i < 8; i++) begin
         v = v[0] ? ((v >> 1) ^ 16'h8408) : (v >> 1);
      end
      return v;
   endfunction
`else
   assign crc_err = 1'b0;
`endif

   // Packet parser FSM; all outputs are registered here.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state         <= ST_IDLE;
         r_hdr_cnt       <= 2'd0;
         r_cnt           <= 16'd0;
         r_crc_ph        <= 1'b0;
         frame_valid     <= 1'b0;
         line_valid      <= 1'b0;
         dat_valid       <= 1'b0;
         dat             <= 8'd0;
         data_type       <= 6'd0;
         virtual_channel <= 2'd0;
         word_count      <= 16'd0;
         pkt_done        <= 1'b0;
         trunc_err       <= 1'b0;
`ifdef MIPI_PKT_CRC_EN
         r_crc           <= 16'hFFFF;
         r_crc_lo        <= 8'd0;
         crc_err         <= 1'b0;
`endif
      end else begin
         dat_valid  <= 1'b0;
         line_valid <= 1'b0;
         pkt_done   <= 1'b0;
         trunc_err  <= 1'b0;
`ifdef MIPI_PKT_CRC_EN
         crc_err    <= 1'b0;
`endif
         case (r_state)
            ST_IDLE: begin
               if (we) begin
                  data_type       <= data[5:0];
                  virtual_channel <= data[7:6];
                  r_hdr_cnt       <= 2'd1;
                  r_state         <= ST_HDR;
               end
            end
            ST_HDR: begin
               if (!we) begin
                  trunc_err <= 1'b1;
                  r_state   <= ST_IDLE;
               end else begin
                  case (r_hdr_cnt)
                     2'd1: begin
                        word_count[7:0] <= data;
                        r_hdr_cnt       <= 2'd2;
                     end
                     2'd2: begin
                        word_count[15:8] <= data;
                        r_hdr_cnt        <= 2'd3;
                     end
                     default: begin
                        // ECC byte: consumed, not checked.
                        r_hdr_cnt <= 2'd0;
                        r_crc_ph  <= 1'b0;
`ifdef MIPI_PKT_CRC_EN
                        r_crc     <= 16'hFFFF;
`endif
                        if (data_type < LONG_DT_MIN) begin
                           pkt_done <= 1'b1;
                           if (data_type == FS_DT) frame_valid <= 1'b1;
                           else if (data_type == FE_DT) frame_valid <= 1'b0;
                           r_state <= ST_DRAIN;
                        end else if (word_count != 16'd0) begin
                           r_cnt   <= word_count;
                           r_state <= ST_PAYLOAD;
                        end else begin
                           r_state <= ST_CRC;
                        end
                     end
                  endcase
               end
            end
            ST_PAYLOAD: begin
               if (!we) begin
                  trunc_err <= 1'b1;
                  r_state   <= ST_IDLE;
               end else begin
                  dat        <= data;
                  dat_valid  <= 1'b1;
                  line_valid <= 1'b1;
                  r_cnt      <= r_cnt - 16'd1;
`ifdef MIPI_PKT_CRC_EN
                  r_crc      <= crc_upd(r_crc, data);
`endif
                  if (r_cnt == 16'd1) r_state <= ST_CRC;
               end
            end
            ST_CRC: begin
               if (!we) begin
                  trunc_err <= 1'b1;
                  r_crc_ph  <= 1'b0;
                  r_state   <= ST_IDLE;
               end else if (!r_crc_ph) begin
                  r_crc_ph <= 1'b1;
`ifdef MIPI_PKT_CRC_EN
                  r_crc_lo <= data;
`endif
               end else begin
                  r_crc_ph <= 1'b0;
                  pkt_done <= 1'b1;
`ifdef MIPI_PKT_CRC_EN
                  crc_err  <= ({data, r_crc_lo} != r_crc);
`endif
                  r_state  <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (!we) r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mipi_csi2_pkt_rx.sv
// tb_mipi_csi2_pkt_rx: scoreboard bench for the CSI-2 packet receiver.
// Payload bytes are queued on drive and popped on dat_valid.
module tb_mipi_csi2_pkt_rx;

   logic        clk = 1'b0;
   logic        reset;
   logic        we;
   logic [7:0]  data;
   logic        frame_valid;
   logic        line_valid;
   logic        dat_valid;
   logic [7:0]  dat;
   logic [5:0]  data_type;
   logic [1:0]  virtual_channel;
   logic [15:0] word_count;
   logic        pkt_done;
   logic        trunc_err;
   logic        crc_err;

`ifdef MIPI_PKT_CRC_EN
   localparam int CRC_ON = 1;
`else
   localparam int CRC_ON = 0;
`endif

   mipi_csi2_pkt_rx dut (
      .clk(clk),
      .reset(reset),
      .we(we),
      .data(data),
      .frame_valid(frame_valid),
      .line_valid(line_valid),
      .dat_valid(dat_valid),
      .dat(dat),
      .data_type(data_type),
      .virtual_channel(virtual_channel),
      .word_count(word_count),
      .pkt_done(pkt_done),
      .trunc_err(trunc_err),
      .crc_err(crc_err)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int n_dv, n_lv, n_pkt, n_trunc, n_crc;
   logic [7:0] exp_q[$];
   logic [7:0] pl[$];
   logic [15:0] c;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // bit-serial LFSR form of the reflected CRC-16
   function automatic logic [15:0] crc16(input int n);
      logic [15:0] r;
      logic fb;
      r = 16'hFFFF;
      for (int i = 0; i < n; i++) begin
         for (int b = 0; b < 8; b++) begin
            fb = r[0] ^ pl[i][b];
            r = r >> 1;
            if (fb) r = r ^ 16'h8408;
         end
      end
      return r;
   endfunction

   // output monitor
   always @(posedge clk) begin
      #1;
      if (dat_valid) begin
         n_dv++;
         if (exp_q.size() == 0) chk("dat_extra", 1, 0);
         else chk("dat", dat, exp_q.pop_front());
      end
      if (line_valid || dat_valid) chk("lv_dv", line_valid, dat_valid);
      if (line_valid) n_lv++;
      if (pkt_done) n_pkt++;
      if (trunc_err) n_trunc++;
      if (crc_err) begin
         n_crc++;
         chk("crc_with_done", pkt_done, 1);
      end
   end

   task automatic clr();
      n_dv = 0; n_lv = 0; n_pkt = 0; n_trunc = 0; n_crc = 0;
   endtask

   task automatic send(input logic [7:0] b);
      @(negedge clk);
      we = 1'b1;
      data = b;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         we = 1'b0;
         data = 8'h00;
      end
   endtask

   task automatic send_short(input logic [7:0] di, input logic [15:0] wc);
      send(di); send(wc[7:0]); send(wc[15:8]); send(8'hA5);
   endtask

   task automatic send_long(input logic [7:0] di, input logic [15:0] wc,
                            input int nsend, input logic [15:0] crc,
                            input int fill);
      send(di); send(wc[7:0]); send(wc[15:8]); send(8'h5A);
      for (int i = 0; i < nsend; i++) begin
         exp_q.push_back(pl[i]);
         send(pl[i]);
      end
      if (nsend == int'(wc)) begin
         send(crc[7:0]);
         send(crc[15:8]);
         for (int i = 0; i < fill; i++) send(8'h00);
      end
   endtask

   initial begin
      reset = 1'b1; we = 1'b0; data = 8'h00;
      clr();
      repeat (3) @(posedge clk);
      #2;
      chk("rst_fv", frame_valid, 0);
      chk("rst_dv", dat_valid, 0);
      chk("rst_wc", word_count, 0);
      chk("rst_dt", data_type, 0);
      @(negedge clk);
      reset = 1'b0;
      idle(2);

      // Frame Start
      clr();
      send_short(8'h00, 16'h0000);
      idle(2);
      chk("fs_fv", frame_valid, 1);
      chk("fs_done", n_pkt, 1);
      chk("fs_wc", word_count, 0);
      chk("fs_dt", data_type, 0);

      // long packet, good CRC
      clr();
      pl = '{8'h11, 8'h22, 8'h33, 8'h44};
      c = crc16(4);
      send_long(8'h2B, 16'd4, 4, c, 0);
      idle(2);
      chk("lp_dv", n_dv, 4);
      chk("lp_lv", n_lv, 4);
      chk("lp_done", n_pkt, 1);
      chk("lp_crc", n_crc, 0);
      chk("lp_dt", data_type, 6'h2B);
      chk("lp_wc", word_count, 4);
      chk("lp_q", exp_q.size(), 0);

      // corrupted payload, stale CRC
      clr();
      pl[2] = 8'h32;
      send_long(8'h2B, 16'd4, 4, c, 0);
      idle(2);
      chk("bad_done", n_pkt, 1);
      chk("bad_crc", n_crc, CRC_ON);
      chk("bad_dv", n_dv, 4);

      // zero-length long packet, CRC is the seed
      clr();
      send_long(8'h6C, 16'd0, 0, 16'hFFFF, 0);
      idle(2);
      chk("z_done", n_pkt, 1);
      chk("z_crc", n_crc, 0);
      chk("z_dv", n_dv, 0);
      chk("z_vc", virtual_channel, 1);

      // truncated payload
      clr();
      pl.delete();
      for (int i = 0; i < 16; i++) pl.push_back(8'(i * 7 + 3));
      send_long(8'h2A, 16'd16, 7, 16'h0000, 0);
      idle(3);
      chk("tr_dv", n_dv, 7);
      chk("tr_err", n_trunc, 1);
      chk("tr_done", n_pkt, 0);
      chk("tr_lv", line_valid, 0);
      chk("tr_fv", frame_valid, 1);

      // next burst parses normally
      clr();
      pl = '{8'hAB, 8'hCD};
      c = crc16(2);
      send_long(8'h2B, 16'd2, 2, c, 0);
      idle(2);
      chk("nx_dv", n_dv, 2);
      chk("nx_done", n_pkt, 1);
      chk("nx_crc", n_crc, 0);
      chk("nx_q", exp_q.size(), 0);

      // reset mid-payload
      clr();
      pl = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
      send_long(8'h2B, 16'd8, 3, 16'h0000, 0);
      @(negedge clk);
      reset = 1'b1; we = 1'b0;
      @(posedge clk);
      #2;
      chk("mr_fv", frame_valid, 0);
      chk("mr_lv", line_valid, 0);
      chk("mr_dv", dat_valid, 0);
      chk("mr_dt", data_type, 0);
      chk("mr_wc", word_count, 0);
      chk("mr_vc", virtual_channel, 0);
      @(negedge clk);
      reset = 1'b0;
      idle(1);
      send_short(8'h01, 16'h0000);
      idle(2);
      chk("mr_fe_fv", frame_valid, 0);
      chk("mr_trunc", n_trunc, 0);
      chk("mr_done", n_pkt, 1);
      chk("mr_dv3", n_dv, 3);

      // FS twice keeps frame_valid high
      clr();
      send_short(8'h00, 16'h0000);
      idle(1);
      send_short(8'h00, 16'h1234);
      idle(2);
      chk("fs2_fv", frame_valid, 1);
      chk("fs2_wc", word_count, 16'h1234);

      // filler after CRC, then FE on VC 1
      clr();
      pl = '{8'h9A, 8'hBC, 8'hDE};
      c = crc16(3);
      send_long(8'h2A, 16'd3, 3, c, 3);
      idle(1);
      chk("fl_done", n_pkt, 1);
      chk("fl_dv", n_dv, 3);
      chk("fl_fv", frame_valid, 1);
      send_short(8'h41, 16'h0000);
      idle(2);
      chk("fe_fv", frame_valid, 0);
      chk("fe_vc", virtual_channel, 1);
      chk("fe_dt", data_type, 6'h01);
      chk("fe_done", n_pkt, 2);
      chk("end_q", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
